// File: rtl/alu_rsv_station.sv
// ALU reservation station: holds dispatched instructions, captures operands from the CDB,
// and issues the lowest-index operand-complete entry to the ALU, holding it until accepted.
module alu_rsv_station #(
    parameter int TAG_W = 4,
    parameter int DEPTH = 4,
    parameter int OP_W  = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dis_valid,
    output logic             dis_ready,
    input  logic [OP_W-1:0]  dis_op,
    input  logic [TAG_W-1:0] dis_tag,
    input  logic [TAG_W-1:0] dis_rs1_tag,
    input  logic [TAG_W-1:0] dis_rs2_tag,
    input  logic [31:0]      dis_rs1_data,
    input  logic [31:0]      dis_rs2_data,
    input  logic             cdb_wr,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_wdata,
    output logic             iss_valid,
    input  logic             iss_ready,
    output logic [OP_W-1:0]  iss_op,
    output logic [TAG_W-1:0] iss_tag,
    output logic [31:0]      iss_rs1,
    output logic [31:0]      iss_rs2,
    output logic [IDX_W:0]   occupancy
);

    logic [DEPTH-1:0] ent_valid;
    logic [OP_W-1:0]  ent_op       [DEPTH];
    logic [TAG_W-1:0] ent_tag      [DEPTH];
    logic [TAG_W-1:0] ent_rs1_tag  [DEPTH];
    logic [TAG_W-1:0] ent_rs2_tag  [DEPTH];
    logic [31:0]      ent_rs1_data [DEPTH];
    logic [31:0]      ent_rs2_data [DEPTH];

    logic             locked;
    logic [IDX_W-1:0] lock_idx;
    logic [IDX_W:0]   count;

    logic [DEPTH-1:0] ent_ready;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] ready_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             do_dispatch;
    logic             do_issue;
    logic             rs1_bypass;
    logic             rs2_bypass;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_ready[i] = ent_valid[i] && (ent_rs1_tag[i] == '0) && (ent_rs2_tag[i] == '0);
        end
    end

    // Descending scan so the lowest matching index wins.
    always_comb begin
        free_idx  = '0;
        ready_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_valid[i]) free_idx = IDX_W'(i);
            if (ent_ready[i])  ready_idx = IDX_W'(i);
        end
    end

    assign dis_ready   = ~&ent_valid;
    assign sel_idx     = locked ? lock_idx : ready_idx;
    assign iss_valid   = locked || (|ent_ready);
    assign do_issue    = iss_valid && iss_ready;
    assign do_dispatch = dis_valid && dis_ready;
    assign occupancy   = count;

    assign iss_op  = iss_valid ? ent_op[sel_idx]       : '0;
    assign iss_tag = iss_valid ? ent_tag[sel_idx]      : '0;
    assign iss_rs1 = iss_valid ? ent_rs1_data[sel_idx] : '0;
    assign iss_rs2 = iss_valid ? ent_rs2_data[sel_idx] : '0;

    assign rs1_bypass = cdb_wr && (dis_rs1_tag != '0) && (dis_rs1_tag == cdb_tag);
    assign rs2_bypass = cdb_wr && (dis_rs2_tag != '0) && (dis_rs2_tag == cdb_tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid <= '0;
            locked    <= 1'b0;
            lock_idx  <= '0;
            count     <= '0;
        end else begin
            if (do_issue) begin
                ent_valid[sel_idx] <= 1'b0;
                locked             <= 1'b0;
            end else if (iss_valid) begin
                locked   <= 1'b1;
                lock_idx <= sel_idx;
            end
            if (do_dispatch) ent_valid[free_idx] <= 1'b1;
            case ({do_dispatch, do_issue})
                2'b10:   count <= count + (IDX_W + 1)'(1);
                2'b01:   count <= count - (IDX_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset: an entry's contents are only observed while it is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && cdb_wr && !(do_issue && (sel_idx == IDX_W'(i)))) begin
                if ((ent_rs1_tag[i] != '0) && (ent_rs1_tag[i] == cdb_tag)) begin
                    ent_rs1_tag[i]  <= '0;
                    ent_rs1_data[i] <= cdb_wdata;
                end
                if ((ent_rs2_tag[i] != '0) && (ent_rs2_tag[i] == cdb_tag)) begin
                    ent_rs2_tag[i]  <= '0;
                    ent_rs2_data[i] <= cdb_wdata;
                end
            end
        end
        if (do_dispatch) begin
            ent_op[free_idx]       <= dis_op;
            ent_tag[free_idx]      <= dis_tag;
            ent_rs1_tag[free_idx]  <= rs1_bypass ? '0 : dis_rs1_tag;
            ent_rs1_data[free_idx] <= rs1_bypass ? cdb_wdata : dis_rs1_data;
            ent_rs2_tag[free_idx]  <= rs2_bypass ? '0 : dis_rs2_tag;
            ent_rs2_data[free_idx] <= rs2_bypass ? cdb_wdata : dis_rs2_data;
        end
    end

endmodule

// File: tb/tb_alu_rsv_station.sv
// Bench for alu_rsv_station: directed scenarios plus randomized traffic, all checked
// against a behavioural model of the station's entries kept in plain arrays.
module tb_alu_rsv_station;

    localparam int TAG_W = 4;
    localparam int DEPTH = 4;
    localparam int OP_W  = 4;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             dis_valid;
    logic             dis_ready;
    logic [OP_W-1:0]  dis_op;
    logic [TAG_W-1:0] dis_tag;
    logic [TAG_W-1:0] dis_rs1_tag;
    logic [TAG_W-1:0] dis_rs2_tag;
    logic [31:0]      dis_rs1_data;
    logic [31:0]      dis_rs2_data;
    logic             cdb_wr;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_wdata;
    logic             iss_valid;
    logic             iss_ready;
    logic [OP_W-1:0]  iss_op;
    logic [TAG_W-1:0] iss_tag;
    logic [31:0]      iss_rs1;
    logic [31:0]      iss_rs2;
    logic [IDX_W:0]   occupancy;

    always #5 clk = ~clk;

    alu_rsv_station #(.TAG_W(TAG_W), .DEPTH(DEPTH), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst),
        .dis_valid(dis_valid), .dis_ready(dis_ready), .dis_op(dis_op), .dis_tag(dis_tag),
        .dis_rs1_tag(dis_rs1_tag), .dis_rs2_tag(dis_rs2_tag),
        .dis_rs1_data(dis_rs1_data), .dis_rs2_data(dis_rs2_data),
        .cdb_wr(cdb_wr), .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_tag(iss_tag),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .occupancy(occupancy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: one record per slot, plus the slot held for issue (-1 when none).
    bit          m_valid [DEPTH];
    int          m_op    [DEPTH];
    int          m_tag   [DEPTH];
    int          m_t1    [DEPTH];
    int          m_t2    [DEPTH];
    logic [31:0] m_d1    [DEPTH];
    logic [31:0] m_d2    [DEPTH];
    int          m_lock = -1;

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", name, observed, expected);
        end
    endtask

    function automatic int model_sel();
        if (m_lock >= 0) return m_lock;
        for (int i = 0; i < DEPTH; i++)
            if (m_valid[i] && m_t1[i] == 0 && m_t2[i] == 0) return i;
        return -1;
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (m_valid[i]) n++;
        return n;
    endfunction

    function automatic int model_free();
        for (int i = 0; i < DEPTH; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        m_lock = -1;
    endtask

    task automatic set_idle();
        rst          = 1'b0;
        dis_valid    = 1'b0;
        dis_op       = '0;
        dis_tag      = '0;
        dis_rs1_tag  = '0;
        dis_rs2_tag  = '0;
        dis_rs1_data = '0;
        dis_rs2_data = '0;
        cdb_wr       = 1'b0;
        cdb_tag      = '0;
        cdb_wdata    = '0;
    endtask

    task automatic drive_dispatch(input int op, input int tag, input int t1, input logic [31:0] d1,
                                  input int t2, input logic [31:0] d2);
        dis_valid    = 1'b1;
        dis_op       = OP_W'(op);
        dis_tag      = TAG_W'(tag);
        dis_rs1_tag  = TAG_W'(t1);
        dis_rs1_data = d1;
        dis_rs2_tag  = TAG_W'(t2);
        dis_rs2_data = d2;
    endtask

    task automatic drive_cdb(input int tag, input logic [31:0] data);
        cdb_wr    = 1'b1;
        cdb_tag   = TAG_W'(tag);
        cdb_wdata = data;
    endtask

    // Checks the current outputs against the model, then advances both across one clock edge.
    task automatic applyStimulus();
        int sel;
        int cnt;
        int free;
        bit hs;
        #1;
        sel = model_sel();
        cnt = model_count();
        checkOutput("dis_ready", 32'(dis_ready), 32'(cnt < DEPTH));
        checkOutput("occupancy", 32'(occupancy), cnt);
        checkOutput("iss_valid", 32'(iss_valid), 32'(sel >= 0));
        checkOutput("iss_op",  32'(iss_op),  (sel >= 0) ? m_op[sel]  : 0);
        checkOutput("iss_tag", 32'(iss_tag), (sel >= 0) ? m_tag[sel] : 0);
        checkOutput("iss_rs1", iss_rs1, (sel >= 0) ? m_d1[sel] : 32'h0);
        checkOutput("iss_rs2", iss_rs2, (sel >= 0) ? m_d2[sel] : 32'h0);
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            hs   = (sel >= 0) && iss_ready;
            free = model_free();
            for (int i = 0; i < DEPTH; i++) begin
                if (m_valid[i] && !(hs && i == sel) && cdb_wr && cdb_tag != 0) begin
                    if (m_t1[i] == int'(cdb_tag)) begin m_t1[i] = 0; m_d1[i] = cdb_wdata; end
                    if (m_t2[i] == int'(cdb_tag)) begin m_t2[i] = 0; m_d2[i] = cdb_wdata; end
                end
            end
            if (hs) begin
                m_valid[sel] = 1'b0;
                m_lock = -1;
            end else if (sel >= 0) begin
                m_lock = sel;
            end
            if (dis_valid && free >= 0) begin
                m_valid[free] = 1'b1;
                m_op[free]    = int'(dis_op);
                m_tag[free]   = int'(dis_tag);
                if (cdb_wr && dis_rs1_tag != 0 && dis_rs1_tag == cdb_tag) begin
                    m_t1[free] = 0; m_d1[free] = cdb_wdata;
                end else begin
                    m_t1[free] = int'(dis_rs1_tag); m_d1[free] = dis_rs1_data;
                end
                if (cdb_wr && dis_rs2_tag != 0 && dis_rs2_tag == cdb_tag) begin
                    m_t2[free] = 0; m_d2[free] = cdb_wdata;
                end else begin
                    m_t2[free] = int'(dis_rs2_tag); m_d2[free] = dis_rs2_data;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        set_idle();
        rst       = 1'b1;
        iss_ready = 1'b0;
        repeat (2) @(posedge clk);
        model_clear();
        @(negedge clk);
        rst = 1'b0;

        checkOutput("reset_iss_valid", 32'(iss_valid), 0);
        checkOutput("reset_dis_ready", 32'(dis_ready), 1);
        checkOutput("reset_occupancy", 32'(occupancy), 0);
        checkOutput("reset_iss_tag",   32'(iss_tag),   0);
        checkOutput("reset_iss_rs1",   iss_rs1,        0);

        // Operands present at dispatch: issue the very next cycle.
        iss_ready = 1'b1;
        drive_dispatch(1, 3, 0, 32'd5, 0, 32'd7);
        applyStimulus();
        set_idle();
        checkOutput("ready_iss_valid", 32'(iss_valid), 1);
        checkOutput("ready_iss_tag",   32'(iss_tag),   3);
        checkOutput("ready_iss_rs1",   iss_rs1,        5);
        checkOutput("ready_iss_rs2",   iss_rs2,        7);
        applyStimulus();
        checkOutput("ready_occ_drained", 32'(occupancy), 0);

        // Wakeup through two separate broadcasts.
        drive_dispatch(2, 2, 5, 32'h0, 6, 32'h0);
        applyStimulus();
        set_idle();
        drive_cdb(5, 32'hAA);
        applyStimulus();
        set_idle();
        checkOutput("wake_not_yet", 32'(iss_valid), 0);
        drive_cdb(6, 32'hBB);
        applyStimulus();
        set_idle();
        checkOutput("wake_iss_valid", 32'(iss_valid), 1);
        checkOutput("wake_iss_tag",   32'(iss_tag),   2);
        checkOutput("wake_iss_rs1",   iss_rs1,        32'hAA);
        checkOutput("wake_iss_rs2",   iss_rs2,        32'hBB);
        applyStimulus();

        // Operand captured from the CDB in the dispatch cycle itself.
        drive_dispatch(3, 4, 9, 32'h0, 0, 32'h22);
        drive_cdb(9, 32'h11);
        applyStimulus();
        set_idle();
        checkOutput("bypass_iss_valid", 32'(iss_valid), 1);
        checkOutput("bypass_iss_rs1",   iss_rs1,        32'h11);
        checkOutput("bypass_iss_rs2",   iss_rs2,        32'h22);
        applyStimulus();

        // Fill under backpressure, try one more, then drain in index order.
        iss_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            drive_dispatch(k, 4 + k, 0, 32'(k), 0, 32'(k));
            applyStimulus();
        end
        set_idle();
        checkOutput("full_dis_ready", 32'(dis_ready), 0);
        checkOutput("full_occupancy", 32'(occupancy), 4);
        checkOutput("full_iss_tag",   32'(iss_tag),   4);
        drive_dispatch(0, 8, 0, 32'h0, 0, 32'h0);
        applyStimulus();
        set_idle();
        checkOutput("full_extra_ignored", 32'(occupancy), 4);
        checkOutput("full_iss_tag_held",  32'(iss_tag),   4);
        iss_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            checkOutput("drain_order", 32'(iss_tag), 4 + k);
            applyStimulus();
        end
        checkOutput("drain_occupancy", 32'(occupancy), 0);

        // A lower slot waking up must not displace a stalled issue.
        iss_ready = 1'b0;
        drive_dispatch(5, 10, 3, 32'h0, 0, 32'h1);
        applyStimulus();
        drive_dispatch(6, 11, 0, 32'h2, 0, 32'h3);
        applyStimulus();
        set_idle();
        checkOutput("lock_first_tag", 32'(iss_tag), 11);
        drive_cdb(3, 32'h33);
        applyStimulus();
        set_idle();
        checkOutput("lock_held_tag", 32'(iss_tag), 11);
        applyStimulus();
        checkOutput("lock_still_held", 32'(iss_tag), 11);
        iss_ready = 1'b1;
        applyStimulus();
        checkOutput("lock_next_tag", 32'(iss_tag), 10);
        checkOutput("lock_next_rs1", iss_rs1,      32'h33);
        applyStimulus();
        checkOutput("lock_occupancy", 32'(occupancy), 0);

        // Reset overrides a stalled issue and a concurrent dispatch.
        iss_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_dispatch(k, 12 + k, 0, 32'h5, 0, 32'h6);
            applyStimulus();
        end
        set_idle();
        applyStimulus();
        rst       = 1'b1;
        iss_ready = 1'b1;
        drive_dispatch(1, 1, 0, 32'h9, 0, 32'h9);
        applyStimulus();
        set_idle();
        checkOutput("rst_occupancy", 32'(occupancy), 0);
        checkOutput("rst_iss_valid", 32'(iss_valid), 0);
        checkOutput("rst_dis_ready", 32'(dis_ready), 1);

        // Randomized traffic with small tag space so matches are frequent.
        for (int c = 0; c < 600; c++) begin
            rst          = ($urandom_range(0, 63) == 0);
            dis_valid    = ($urandom_range(0, 9) < 6);
            dis_op       = OP_W'($urandom);
            dis_tag      = TAG_W'($urandom_range(1, 15));
            dis_rs1_tag  = $urandom_range(0, 1) ? '0 : TAG_W'($urandom_range(1, 7));
            dis_rs2_tag  = $urandom_range(0, 1) ? '0 : TAG_W'($urandom_range(1, 7));
            dis_rs1_data = $urandom;
            dis_rs2_data = $urandom;
            cdb_wr       = $urandom_range(0, 1) == 1;
            cdb_tag      = TAG_W'($urandom_range(0, 7));
            cdb_wdata    = $urandom;
            iss_ready    = ($urandom_range(0, 2) != 0);
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
